// File: rtl/array_drain.sv
// array_drain: walks the MAC array PE-select index in row-major order, captures
// each accumulator from the array's combinational d_out and streams it out over
// a valid/ready interface.
// Optional feature macro: ARRAY_DRAIN_SAT_EN (saturate captured values to the
// signed 16-bit range, sign-extended to 32 bits).
module array_drain #(
  parameter int unsigned SIZE = 16,
  parameter int unsigned IW   = $clog2(SIZE * SIZE)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  output logic [SIZE*SIZE-1:0]   select,
  input  logic [31:0]            d_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_data,
  output logic [IW-1:0]          out_index,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned N  = SIZE * SIZE;
  localparam int unsigned SW = SIZE * SIZE;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    PRESENT = 2'd2,
    FINISH  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [SW-1:0]   select_q, select_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_data_q, out_data_d;
  logic [IW-1:0]   out_index_q, out_index_d;
  logic            out_last_q, out_last_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [31:0]     cap_c;
  logic [IW-1:0]   idx_inc_c;

`ifdef ARRAY_DRAIN_SAT_EN
  // Clamp a signed 32-bit value into the signed 16-bit range, kept sign-extended.
  function automatic logic [31:0] sat16(input logic [31:0] v);
    if ($signed(v) > 32'sd32767) begin
      return 32'h0000_7FFF;
    end else if ($signed(v) < -32'sd32768) begin
      return 32'hFFFF_8000;
    end else begin
      return v;
    end
  endfunction
`endif

  // Value to be registered into out_data at capture time.
  always_comb begin
`ifdef ARRAY_DRAIN_SAT_EN
    cap_c = sat16(d_in);
`else
    cap_c = d_in;
`endif
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    select_d    = select_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    idx_inc_c   = idx_q + IW'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d    = '0;
          select_d = '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        if (abort) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end else begin
          out_data_d  = cap_c;
          out_index_d = idx_q;
          out_valid_d = 1'b1;
          out_last_d  = (idx_q == IW'(N - 1));
          state_d     = PRESENT;
        end
      end
      PRESENT: begin
        if (abort) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (out_last_q) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            idx_d    = idx_inc_c;
            select_d = SW'(idx_inc_c);
            state_d  = SETUP;
          end
        end
      end
      FINISH: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      select_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      select_q    <= select_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign select    = select_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_array_drain.sv
// Testbench for array_drain with SIZE=2; array model returns d_tab[select].
module tb_array_drain;

  localparam int unsigned SIZE = 2;
  localparam int unsigned N    = SIZE * SIZE;
  localparam int unsigned IW   = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [N-1:0]     select;
  logic [31:0]      d_in;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [IW-1:0]    out_index;
  logic             out_last;
  logic             busy;
  logic             done;

  array_drain #(.SIZE(SIZE), .IW(IW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .select(select),
    .d_in(d_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [31:0] d_tab [N];
  assign d_in = d_tab[select[IW-1:0]];

  typedef struct packed {
    logic [31:0]   data;
    logic [IW-1:0] index;
    logic          last;
  } res_t;

  typedef struct {
    logic          v;
    logic [IW-1:0] idx;
    logic          last;
    logic          dn;
    logic          bsy;
  } vec_t;

  typedef struct {
    logic [31:0] din;
    logic [31:0] sat_exp;
  } sat_vec_t;

  res_t sb[$];
  res_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   t0 = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int rel();
    return cyc - t0 + 1;
  endfunction

  // Scoreboard: compare every accepted result against the queue head.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (!reset && out_valid && out_ready && !abort) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got index %0d data %0h, none expected", out_index, out_data);
      end else begin
        mon_e = sb.pop_front();
        check("data", out_data, mon_e.data);
        check("index", 32'(out_index), 32'(mon_e.index));
        check("last", 32'(out_last), 32'(mon_e.last));
        check("select", 32'(select), 32'(out_index));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_default_tab();
    for (int i = 0; i < int'(N); i++) d_tab[i] = 32'(100 + i);
  endtask

  task automatic push_tab();
    for (int i = 0; i < int'(N); i++)
      sb.push_back(res_t'{d_tab[i], IW'(i), (i == int'(N) - 1)});
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_done(input string name, input int exp_cyc);
    int when;
    when = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done) begin
        when = rel();
        break;
      end
    end
    check(name, 32'(when), 32'(exp_cyc));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_data"},  out_data, 32'd0);
    check({tag, "_index"}, 32'(out_index), 32'd0);
    check({tag, "_last"},  32'(out_last), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_select"}, 32'(select), 32'd0);
  endtask

  vec_t     tab [10];
  sat_vec_t sat_tab [4];
  int       dc;

  initial begin
    // Cycle-by-cycle expectations for a full drain with out_ready high (cycles 1..10).
    tab[0] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1};
    tab[1] = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b1};
    tab[2] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1};
    tab[3] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1};
    tab[4] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1};
    tab[5] = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b1};
    tab[6] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1};
    tab[7] = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b1};
    tab[8] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1};
    tab[9] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0};

    sat_tab[0] = '{32'h0001_0000, 32'h0000_7FFF};
    sat_tab[1] = '{32'hFFFE_0000, 32'hFFFF_8000};
    sat_tab[2] = '{32'h0000_1234, 32'h0000_1234};
    sat_tab[3] = '{32'h8000_0000, 32'hFFFF_8000};

    set_default_tab();
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    step();

    // Full drain, ready high, table-checked per cycle.
    push_tab();
    do_start();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("fd_valid_c%0d", k + 1), 32'(out_valid), 32'(tab[k].v));
      check($sformatf("fd_done_c%0d", k + 1), 32'(done), 32'(tab[k].dn));
      check($sformatf("fd_busy_c%0d", k + 1), 32'(busy), 32'(tab[k].bsy));
      if (tab[k].v) begin
        check($sformatf("fd_index_c%0d", k + 1), 32'(out_index), 32'(tab[k].idx));
        check($sformatf("fd_last_c%0d", k + 1), 32'(out_last), 32'(tab[k].last));
      end
      step();
    end
    check("fd_sb_empty", 32'(sb.size()), 32'd0);

    // Backpressure: index 1 held for 5 cycles.
    step();
    push_tab();
    do_start();
    step();
    step();
    out_ready = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", out_data, 32'd101);
      check("bp_index", 32'(out_index), 32'd1);
      step();
    end
    out_ready = 1'b1;
    wait_done("bp_done_cycle", 14);
    check("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Abort during PRESENT at index 2 with ready high.
    step(); step();
    push_tab();
    do_start();
    for (int k = 0; k < 5; k++) step();
    abort = 1'b1;
    dc = done_cnt;
    step();
    abort = 1'b0;
    @(negedge clk);
    check("ab_valid", 32'(out_valid), 32'd0);
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_last", 32'(out_last), 32'd0);
    for (int k = 0; k < 12; k++) step();
    check("ab_no_done", 32'(done_cnt), 32'(dc));
    check("ab_dropped", 32'(sb.size()), 32'd2);
    sb.delete();
    push_tab();
    do_start();
    wait_done("ab_restart_done", 9);
    check("ab_sb_empty", 32'(sb.size()), 32'd0);

    // Start while busy is ignored.
    step(); step();
    dc = done_cnt;
    push_tab();
    do_start();
    step(); step(); step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("sb_done_cycle", 9);
    for (int k = 0; k < 8; k++) step();
    check("sb_one_done", 32'(done_cnt - dc), 32'd1);
    check("sb_sb_empty", 32'(sb.size()), 32'd0);

    // Async reset between clock edges while in PRESENT.
    push_tab();
    do_start();
    step();
    #2;
    reset = 1'b1;
    #1;
    check_zero_outputs("ar");
    @(posedge clk); #3;
    reset = 1'b0;
    sb.delete();
    step();
    push_tab();
    do_start();
    wait_done("ar_done_cycle", 9);
    check("ar_sb_empty", 32'(sb.size()), 32'd0);

    // Saturation / pass-through table.
    step();
    for (int i = 0; i < int'(N); i++) begin
      d_tab[i] = sat_tab[i].din;
`ifdef ARRAY_DRAIN_SAT_EN
      sb.push_back(res_t'{sat_tab[i].sat_exp, IW'(i), (i == int'(N) - 1)});
`else
      sb.push_back(res_t'{sat_tab[i].din, IW'(i), (i == int'(N) - 1)});
`endif
    end
    do_start();
    wait_done("sat_done_cycle", 9);
    check("sat_sb_empty", 32'(sb.size()), 32'd0);

    step(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
